// File: rtl/seq_div_16_8_if.sv
// seq_div_16_8_if: operand/result handshake bundle for the sequential divider.
interface seq_div_16_8_if #(parameter int N = 16, parameter int M = 8);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] IN1;
   logic [M-1:0] IN2;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] Quo;
   logic [M-1:0] Rem;
   logic         dbz;
   modport master (
      output in_valid, IN1, IN2, out_ready,
      input  in_ready, out_valid, Quo, Rem, dbz
   );
   modport slave (
      input  in_valid, IN1, IN2, out_ready,
      output in_ready, out_valid, Quo, Rem, dbz
   );
endinterface

// File: rtl/seq_div_16_8.sv
// seq_div_16_8: exact restoring divider, N-bit dividend by M-bit divisor,
// one quotient bit per cycle behind valid/ready handshakes.
module seq_div_16_8 #(
   parameter int N = 16,
   parameter int M = 8
) (
   input logic           clk,
   input logic           rst,
   seq_div_16_8_if.slave bus
);
   localparam int CW = $clog2(N + 1);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   logic [1:0]    state;
   logic [M-1:0]  p, d, rem, p_nxt;
   logic [N-1:0]  q, quo, q_nxt;
   logic [CW-1:0] cnt;
   logic [M:0]    t;
   logic          ge, dbz;
   always_comb begin
      t = {p, q[N-1]};
      ge = t >= {1'b0, d};
      // P < D holds after every step, so the difference always fits in M bits
      p_nxt = ge ? M'(t - {1'b0, d}) : t[M-1:0];
      q_nxt = (q << 1) | N'(ge);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         p     <= '0;
         d     <= '0;
         q     <= '0;
         cnt   <= '0;
         quo   <= '0;
         rem   <= '0;
         dbz   <= 1'b0;
      end else if (state == IDLE) begin
         if (bus.in_valid) begin
            if (bus.IN2 != '0) begin
               d     <= bus.IN2;
               q     <= bus.IN1;
               p     <= '0;
               cnt   <= '0;
               state <= RUN;
            end else begin
               quo   <= '1;
               rem   <= bus.IN1[M-1:0];
               dbz   <= 1'b1;
               state <= DONE;
            end
         end
      end else if (state == RUN) begin
         p   <= p_nxt;
         q   <= q_nxt;
         cnt <= cnt + CW'(1);
         if (cnt == LAST) begin
            quo   <= q_nxt;
            rem   <= p_nxt;
            dbz   <= 1'b0;
            state <= DONE;
         end
      end else if (bus.out_ready) state <= IDLE;
   assign bus.in_ready  = state == IDLE;
   assign bus.out_valid = state == DONE;
   assign bus.Quo       = quo;
   assign bus.Rem       = rem;
   assign bus.dbz       = dbz;
endmodule

// File: tb/tb_seq_div_16_8.sv
// tb_seq_div_16_8: directed corner cases plus a random sweep, all results
// checked against an arithmetic scoreboard of accepted operations.
module tb_seq_div_16_8;
   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   int   n_acc = 0;
   int   n_done = 0;
   typedef struct {
      logic [15:0] a;
      logic [7:0]  b;
      logic [15:0] q;
      logic [7:0]  r;
      logic        z;
   } res_t;
   res_t sb[$];
   seq_div_16_8_if #(.N(16), .M(8)) bus ();
   seq_div_16_8 #(.N(16), .M(8)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask
   // scoreboard: record every accepted operation, compare every valid result cycle
   always @(negedge clk) begin
      res_t e;
      if (rst) sb.delete();
      else begin
         chk("handshake_excl", 32'(bus.in_ready & bus.out_valid), 0);
         if (bus.out_valid) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
               chk("sb_quo", 32'(bus.Quo), 32'(sb[0].q));
               chk("sb_rem", 32'(bus.Rem), 32'(sb[0].r));
               chk("sb_dbz", 32'(bus.dbz), 32'(sb[0].z));
               if (!sb[0].z) begin
                  chk("sb_identity", 32'(bus.Quo) * 32'(sb[0].b) + 32'(bus.Rem), 32'(sb[0].a));
                  chk("sb_rem_lt", 32'(bus.Rem < sb[0].b), 1);
               end
               if (bus.out_ready) begin
                  void'(sb.pop_front());
                  n_done++;
               end
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            e.a = bus.IN1;
            e.b = bus.IN2;
            e.z = bus.IN2 == 8'd0;
            e.q = e.z ? 16'hFFFF : bus.IN1 / 16'(bus.IN2);
            e.r = e.z ? bus.IN1[7:0] : 8'(bus.IN1 % 16'(bus.IN2));
            sb.push_back(e);
            n_acc++;
         end
      end
   end
   task automatic do_op(input logic [15:0] a, input logic [7:0] b, input logic [15:0] eq,
                        input logic [7:0] er, input logic ez, input int elat, input int hold);
      string tag;
      int lat;
      tag = $sformatf("%0d/%0d", a, b);
      @(posedge clk);
      #1 bus.IN1 = a;
      bus.IN2 = b;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b0;
      @(negedge clk) chk({tag, " ready_before"}, 32'(bus.in_ready), 1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      lat = 1;
      @(negedge clk);
      if (!bus.out_valid) chk({tag, " ready_drop"}, 32'(bus.in_ready), 0);
      while (!bus.out_valid && lat < 40) begin
         @(posedge clk);
         lat++;
         #2 bus.IN1 = 16'($urandom);
         bus.IN2 = 8'($urandom);
         @(negedge clk);
      end
      chk({tag, " latency"}, lat, elat);
      chk({tag, " quo"}, 32'(bus.Quo), 32'(eq));
      chk({tag, " rem"}, 32'(bus.Rem), 32'(er));
      chk({tag, " dbz"}, 32'(bus.dbz), 32'(ez));
      repeat (hold) begin
         @(posedge clk);
         #2 bus.IN1 = 16'($urandom);
         bus.IN2 = 8'($urandom);
         @(negedge clk);
         chk({tag, " hold_valid"}, 32'(bus.out_valid), 1);
         chk({tag, " hold_ready"}, 32'(bus.in_ready), 0);
         chk({tag, " hold_quo"}, 32'(bus.Quo), 32'(eq));
         chk({tag, " hold_rem"}, 32'(bus.Rem), 32'(er));
      end
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      @(negedge clk);
      chk({tag, " ready_return"}, 32'(bus.in_ready), 1);
      chk({tag, " valid_drop"}, 32'(bus.out_valid), 0);
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.IN1 = '0;
      bus.IN2 = '0;
      repeat (3) @(posedge clk);
      #1 chk("reset in_ready", 32'(bus.in_ready), 1);
      chk("reset out_valid", 32'(bus.out_valid), 0);
      chk("reset quo", 32'(bus.Quo), 0);
      chk("reset rem", 32'(bus.Rem), 0);
      chk("reset dbz", 32'(bus.dbz), 0);
      #1 rst = 1'b0;
      do_op(16'd300, 8'd17, 16'd17, 8'd11, 1'b0, 17, 0);
      do_op(16'd65535, 8'd255, 16'd257, 8'd0, 1'b0, 17, 0);
      do_op(16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0, 17, 0);
      do_op(16'd5, 8'd9, 16'd0, 8'd5, 1'b0, 17, 0);
      do_op(16'd0, 8'd3, 16'd0, 8'd0, 1'b0, 17, 0);
      do_op(16'd1234, 8'd0, 16'hFFFF, 8'hD2, 1'b1, 1, 0);
      do_op(16'd1234, 8'd7, 16'd176, 8'd2, 1'b0, 17, 0);
      do_op(16'd40000, 8'd200, 16'd200, 8'd0, 1'b0, 17, 10);
      // abort 1000/3 after its eighth iteration
      @(posedge clk);
      #1 bus.IN1 = 16'd1000;
      bus.IN2 = 8'd3;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1 chk("abort busy", 32'(bus.in_ready), 0);
      #1 rst = 1'b1;
      #1 chk("abort in_ready", 32'(bus.in_ready), 1);
      chk("abort out_valid", 32'(bus.out_valid), 0);
      chk("abort quo", 32'(bus.Quo), 0);
      chk("abort rem", 32'(bus.Rem), 0);
      chk("abort dbz", 32'(bus.dbz), 0);
      @(posedge clk);
      #2 rst = 1'b0;
      do_op(16'd1000, 8'd3, 16'd333, 8'd1, 1'b0, 17, 0);
      n_acc = 0;
      n_done = 0;
      for (int i = 0; i < 40000; i++) begin
         @(posedge clk);
         #1 bus.in_valid = $urandom_range(0, 3) != 0;
         bus.out_ready = $urandom_range(0, 3) != 0;
         bus.IN1 = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 300)) : 16'($urandom);
         bus.IN2 = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      end
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      chk("drain_empty", 32'(sb.size()), 0);
      chk("acc_vs_done", n_done, n_acc);
      chk("sweep_nonzero", 32'(n_acc > 1000), 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
